// File: rtl/sp_ram_fifo_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : sp_ram_fifo_ctrl
// Description : Synchronous FIFO controller that runs one single-port RAM
//               (DEPTH x DW, shared address, write enable, bidirectional data
//               bus). Pushes (RAM writes) and prefetch reads share the port
//               under round-robin arbitration. A registered output entry
//               decouples pop data from the RAM.
// Ports       : clk_i, rst_i            - clock, synchronous active-high reset
//               push_valid_i/ready_o    - producer handshake, push_data_i
//               pop_valid_o/ready_i     - consumer handshake, pop_data_o
//               count_o                 - RAM occupancy plus output entry
//               full_o, empty_o         - RAM full, output entry empty
//               ram_rst_n_o, ram_we_o,
//               ram_addr_o, ram_data_io - RAM port
//               almost_full_o           - only with SP_RAM_FIFO_ALMOST_FULL_EN
// Options     : SP_RAM_FIFO_ALMOST_FULL_EN adds the registered almost_full_o
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module sp_ram_fifo_ctrl #(
   parameter int DEPTH     = 128,
   parameter int AW        = 7,
   parameter int DW        = 8,
   parameter int AF_THRESH = 120
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          push_valid_i,
   input  logic [DW-1:0] push_data_i,
   output logic          push_ready_o,
   output logic          pop_valid_o,
   output logic [DW-1:0] pop_data_o,
   input  logic          pop_ready_i,
   output logic [AW:0]   count_o,
   output logic          full_o,
   output logic          empty_o,
   output logic          ram_rst_n_o,
   output logic          ram_we_o,
   output logic [AW-1:0] ram_addr_o,
   inout  wire  [DW-1:0] ram_data_io
`ifdef SP_RAM_FIFO_ALMOST_FULL_EN
   ,
   output logic          almost_full_o
`endif
);

   localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] c_LAST    = AW'(DEPTH-1);
   localparam logic [AW-1:0] c_PTR_ONE = AW'(1);
   localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_ram_cnt;
   logic          r_out_valid;
   logic [DW-1:0] r_out_data;
   logic          r_last_grant;   // 0 = write won last contention, 1 = read

   logic          w_wr_req;
   logic          w_rd_req;
   logic          w_wr_gnt;
   logic          w_rd_gnt;
   logic          w_pop;
   logic [AW:0]   w_ram_cnt_nxt;
   logic          w_out_valid_nxt;

   always_comb begin
      w_wr_req = 1'b0;
      w_rd_req = 1'b0;
      w_wr_gnt = 1'b0;
      w_rd_gnt = 1'b0;
      if (!rst_i) begin
         w_wr_req = push_valid_i && (r_ram_cnt != c_DEPTH);
         // Prefetch only when the output entry is free or is being drained.
         w_rd_req = (r_ram_cnt != '0) && (!r_out_valid || pop_ready_i);
      end
      if (w_wr_req && w_rd_req) begin
         w_wr_gnt = r_last_grant;
         w_rd_gnt = !r_last_grant;
      end else begin
         w_wr_gnt = w_wr_req;
         w_rd_gnt = w_rd_req;
      end
   end

   assign w_pop = r_out_valid && pop_ready_i;

   always_comb begin
      w_ram_cnt_nxt = r_ram_cnt;
      if (w_wr_gnt) begin
         w_ram_cnt_nxt = r_ram_cnt + c_CNT_ONE;
      end else if (w_rd_gnt) begin
         w_ram_cnt_nxt = r_ram_cnt - c_CNT_ONE;
      end
      w_out_valid_nxt = r_out_valid;
      if (w_rd_gnt) begin
         w_out_valid_nxt = 1'b1;
      end else if (w_pop) begin
         w_out_valid_nxt = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_ram_cnt    <= '0;
         r_out_valid  <= 1'b0;
         r_out_data   <= '0;
         r_last_grant <= 1'b0;
      end else begin
         r_ram_cnt   <= w_ram_cnt_nxt;
         r_out_valid <= w_out_valid_nxt;
         if (w_wr_gnt) begin
            r_wr_ptr <= (r_wr_ptr == c_LAST) ? '0 : r_wr_ptr + c_PTR_ONE;
         end
         if (w_rd_gnt) begin
            r_out_data <= ram_data_io;
            r_rd_ptr   <= (r_rd_ptr == c_LAST) ? '0 : r_rd_ptr + c_PTR_ONE;
         end
         // Round-robin state moves only when both sides wanted the port.
         if (w_wr_req && w_rd_req) begin
            r_last_grant <= w_rd_gnt;
         end
      end
   end

   assign push_ready_o = w_wr_gnt;
   assign ram_we_o     = w_wr_gnt;
   assign ram_addr_o   = w_wr_gnt ? r_wr_ptr : r_rd_ptr;
   assign ram_data_io  = w_wr_gnt ? push_data_i : {DW{1'bz}};
   assign ram_rst_n_o  = ~rst_i;
   assign pop_valid_o  = r_out_valid;
   assign pop_data_o   = r_out_data;
   assign count_o      = r_ram_cnt + {{AW{1'b0}}, r_out_valid};
   assign full_o       = (r_ram_cnt == c_DEPTH);
   assign empty_o      = !r_out_valid;

`ifdef SP_RAM_FIFO_ALMOST_FULL_EN
   localparam logic [AW:0] c_AF_THRESH = (AW+1)'(AF_THRESH);

   logic [AW:0] w_count_nxt;
   logic        r_almost_full;

   // Registered from the next-cycle occupancy so the flag lines up with count_o.
   assign w_count_nxt = w_ram_cnt_nxt + {{AW{1'b0}}, w_out_valid_nxt};

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_almost_full <= 1'b0;
      end else begin
         r_almost_full <= (w_count_nxt >= c_AF_THRESH);
      end
   end

   assign almost_full_o = r_almost_full;
`else
   // The threshold only matters when the almost-full output is built.
   logic w_unused_af_thresh;
   assign w_unused_af_thresh = (AF_THRESH > 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_sp_ram_fifo_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : tb_sp_ram_fifo_ctrl
// Description : Directed self-checking bench for sp_ram_fifo_ctrl with a
//               behavioural single-port RAM on the bidirectional bus.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_sp_ram_fifo_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       push_valid;
   logic [7:0] push_data;
   logic       pop_ready;
   wire        push_ready;
   wire        pop_valid;
   wire  [7:0] pop_data;
   wire  [7:0] count;
   wire        full;
   wire        empty;
   wire        ram_rst_n;
   wire        ram_we;
   wire  [6:0] ram_addr;
   wire  [7:0] ram_data;
`ifdef SP_RAM_FIFO_ALMOST_FULL_EN
   wire        almost_full;
`endif

   int         n_total = 0;
   int         n_bad   = 0;
   logic [7:0] sb[$];
   logic [7:0] mem[128];
   logic       last_push;
   logic       cyc_we;
   logic       prev_we;
   logic [7:0] next_d;

   always #5 clk = ~clk;

   sp_ram_fifo_ctrl dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .push_valid_i (push_valid),
      .push_data_i  (push_data),
      .push_ready_o (push_ready),
      .pop_valid_o  (pop_valid),
      .pop_data_o   (pop_data),
      .pop_ready_i  (pop_ready),
      .count_o      (count),
      .full_o       (full),
      .empty_o      (empty),
      .ram_rst_n_o  (ram_rst_n),
      .ram_we_o     (ram_we),
      .ram_addr_o   (ram_addr),
      .ram_data_io  (ram_data)
`ifdef SP_RAM_FIFO_ALMOST_FULL_EN
      ,
      .almost_full_o(almost_full)
`endif
   );

   // Single-port RAM: asynchronous read drive when not writing.
   assign ram_data = ram_we ? 8'hzz : mem[ram_addr];

   always @(posedge clk) begin
      if (!ram_rst_n) begin
         for (int i = 0; i < 128; i++) mem[i] <= 8'h00;
      end else if (ram_we) begin
         mem[ram_addr] <= ram_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Settle, log handshakes into the scoreboard, then advance one clock.
   task automatic cycle();
      #1;
      cyc_we    = ram_we;
      last_push = push_valid && push_ready;
      if (last_push) sb.push_back(push_data);
      if (pop_valid && pop_ready) begin
         if (sb.size() == 0) chk("pop_unexpected", 1, 0);
         else begin
            chk("pop_data", pop_data, sb[0]);
            void'(sb.pop_front());
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [7:0] d);
      push_valid = 1'b1;
      push_data  = d;
      last_push  = 1'b0;
      for (int k = 0; k < 10; k++) begin
         cycle();
         if (last_push) break;
      end
      if (!last_push) chk("push_timeout", 0, 1);
      push_valid = 1'b0;
   endtask

   task automatic drain(input int exp_words);
      int n;
      n = 0;
      pop_ready = 1'b1;
      for (int k = 0; k < 600; k++) begin
         #1;
         if (!pop_valid && count == 8'd0) break;
         if (pop_valid) n++;
         cycle();
      end
      pop_ready = 1'b0;
      #1;
      chk("drain_words", n, exp_words);
      chk("drain_empty", empty, 1);
      chk("drain_count", count, 0);
      chk("drain_sb", sb.size(), 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, with a push attempt held during reset.
      rst        = 1'b1;
      push_valid = 1'b1;
      push_data  = 8'h11;
      pop_ready  = 1'b0;
      #1;
      chk("rst_we", ram_we, 0);
      chk("rst_push_ready", push_ready, 0);
      chk("rst_ram_rst_n", ram_rst_n, 0);
      cycle();
      cycle();
      rst        = 1'b0;
      push_valid = 1'b0;
      #1;
      chk("idle_count", count, 0);
      chk("idle_empty", empty, 1);
      chk("idle_full", full, 0);
      chk("idle_pop_valid", pop_valid, 0);
      chk("idle_we", ram_we, 0);
      chk("idle_ram_rst_n", ram_rst_n, 1);

      // Single word latency.
      push_valid = 1'b1;
      push_data  = 8'hA5;
      #1;
      chk("a5_ready", push_ready, 1);
      chk("a5_we", ram_we, 1);
      chk("a5_addr", ram_addr, 0);
      chk("a5_bus", ram_data, 8'hA5);
      cycle();
      push_valid = 1'b0;
      #1;
      chk("a5_n1_valid", pop_valid, 0);
      chk("a5_n1_count", count, 1);
      chk("a5_rd_we", ram_we, 0);
      chk("a5_rd_addr", ram_addr, 0);
      cycle();
      chk("a5_n2_valid", pop_valid, 1);
      chk("a5_n2_data", pop_data, 8'hA5);
      chk("a5_n2_count", count, 1);
      pop_ready = 1'b1;
      cycle();
      pop_ready = 1'b0;
      chk("a5_popped_empty", empty, 1);
      chk("a5_popped_count", count, 0);

      // Fill 129 words, then one more attempt must stall.
      for (int i = 0; i <= 8'h80; i++) push_word(8'(i));
      #1;
      chk("fill_full", full, 1);
      chk("fill_count", count, 129);
      push_valid = 1'b1;
      push_data  = 8'h81;
      #1;
      chk("fill_stall", push_ready, 0);
      push_valid = 1'b0;
      drain(129);

      // Streaming with 64 words preloaded: port alternates every cycle.
      for (int i = 0; i < 64; i++) push_word(8'(i * 3));
      next_d     = 8'hC0;
      push_valid = 1'b1;
      pop_ready  = 1'b1;
      prev_we    = 1'b0;
      for (int i = 0; i < 200; i++) begin
         push_data = next_d;
         cycle();
         if (last_push) next_d = next_d + 8'd1;
         if (i > 0) chk("stream_we_alt", cyc_we, !prev_we);
         prev_we = cyc_we;
      end
      push_valid = 1'b0;
      drain(64);

      // Reset in the middle of operation.
      for (int i = 0; i < 50; i++) push_word(8'(8'h60 + i));
      #1;
      chk("pre_rst_count", count, 50);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      sb.delete();
      #1;
      chk("post_rst_count", count, 0);
      chk("post_rst_valid", pop_valid, 0);
      push_valid = 1'b1;
      push_data  = 8'h3C;
      #1;
      chk("post_rst_addr", ram_addr, 0);
      chk("post_rst_we", ram_we, 1);
      cycle();
      push_valid = 1'b0;
      for (int k = 0; k < 5; k++) begin
         if (pop_valid) break;
         cycle();
      end
      chk("post_rst_pop_valid", pop_valid, 1);
      chk("post_rst_pop_data", pop_data, 8'h3C);
      drain(1);

`ifdef SP_RAM_FIFO_ALMOST_FULL_EN
      for (int i = 0; i < 119; i++) push_word(8'(i));
      #1;
      chk("af_119_count", count, 119);
      chk("af_119", almost_full, 0);
      push_word(8'd119);
      #1;
      chk("af_120_count", count, 120);
      chk("af_120", almost_full, 1);
      pop_ready = 1'b1;
      cycle();
      pop_ready = 1'b0;
      cycle();
      chk("af_pop_count", count, 119);
      chk("af_pop", almost_full, 0);
      drain(119);
`endif

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
